pipe_issue: RTL and testbench

- Instruction issue sequencer that drives the rs1/rs2/rd/func/addr fields of the 4-stage pipeline from a small internal program store.
- Acts as the initiator for the pipeline, which consumes one instruction field set per clock.
- Detects read-after-write hazards against recently issued destinations and inserts bubbles, since the pipeline has no forwarding.
- Loaded by host/testbench, started with a count, signals completion after the pipeline drains.

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/pipe_hazard_win.sv | 47 ++++
 rtl/pipe_issue.sv | 146 ++++++++++++++
 tb/tb_pipe_issue.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the issue sequencer and the 4-stage pipeline:
// field widths, func encodings, instruction word layout and FSM states.
package pipe_pkg;

  localparam int unsigned REG_W  = 4;
  localparam int unsigned FUNC_W = 2;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned WORD_W = 22;

  localparam logic [FUNC_W-1:0] FUNC_ADD = 2'b00;
  localparam logic [FUNC_W-1:0] FUNC_SUB = 2'b01;

  // Instruction word bit positions (MSB of each field)
  localparam int unsigned FUNC_MSB = 21;
  localparam int unsigned RD_MSB   = 19;
  localparam int unsigned RS1_MSB  = 15;
  localparam int unsigned RS2_MSB  = 11;
  localparam int unsigned ADDR_MSB = 7;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pipe_hazard_win.sv
// Window of the last HAZ_WIN issue slots ({valid, rd}) with RAW match logic.
// Entry 0 is the instruction currently on the issue outputs.
module pipe_hazard_win
  import pipe_pkg::*;
#(
  parameter int unsigned HAZ_WIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic             push_v,
  input  logic [REG_W-1:0] push_rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  output logic             hazard
);

  logic [HAZ_WIN-1:0] v;
  logic [REG_W-1:0]   rdq [HAZ_WIN];

  // Shift one slot per RUN cycle; bubbles push an invalid entry
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int unsigned i = 0; i < HAZ_WIN; i++) begin
        v[i]   <= 1'b0;
        rdq[i] <= '0;
      end
    end else if (shift) begin
      for (int unsigned i = HAZ_WIN - 1; i >= 1; i--) begin
        v[i]   <= v[i-1];
        rdq[i] <= rdq[i-1];
      end
      v[0]   <= push_v;
      rdq[0] <= push_rd;
    end
  end

  // Hazard when any valid entry writes a register the candidate reads (r0 included)
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < HAZ_WIN; i++) begin
      if (v[i] && ((rdq[i] == rs1) || (rdq[i] == rs2))) hazard = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_issue.sv
// Instruction issue sequencer: issues program slots 0..count-1 into the
// pipeline, inserting bubbles on RAW hazards, then drains and pulses done.
module pipe_issue
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AW        = 4,
  parameter int unsigned HAZ_WIN   = 2,
  parameter int unsigned DRAIN_CYC = 4,
  parameter logic [21:0] NOP_WORD  = 22'h0
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_idx,
  input  logic [21:0]   load_word,
  input  logic          start,
  input  logic [AW:0]   count,
  output logic [3:0]    rs1,
  output logic [3:0]    rs2,
  output logic [3:0]    rd,
  output logic [1:0]    func,
  output logic [7:0]    addr,
  output logic          issue_valid,
  output logic          busy,
  output logic          done,
  output logic [15:0]   stall_cnt
);

  localparam int unsigned DCW = $clog2(DRAIN_CYC + 1);

  state_t         state;
  logic [AW-1:0]  pc;
  logic [AW-1:0]  last;
  logic [AW-1:0]  last_n;
  logic [AW:0]    cnt_cl;
  logic [DCW-1:0] dcnt;
  instr_t         prog [DEPTH];
  instr_t         cand;
  instr_t         outw;
  logic           hazard;
  logic           win_clr;
  logic           win_shift;

  assign cand = prog[pc];

  assign func = outw.func;
  assign rd   = outw.rd;
  assign rs1  = outw.rs1;
  assign rs2  = outw.rs2;
  assign addr = outw.addr;

  // Clamp count to DEPTH and derive the index of the final slot
  always_comb begin
    cnt_cl = count;
    if (count > (AW+1)'(DEPTH)) cnt_cl = (AW+1)'(DEPTH);
    last_n    = AW'(cnt_cl - 1'b1);
    win_clr   = (state == ST_IDLE) && start;
    win_shift = (state == ST_RUN);
  end

  pipe_hazard_win #(
    .HAZ_WIN (HAZ_WIN)
  ) u_win (
    .clk     (clk1),
    .rst     (rst),
    .clr     (win_clr),
    .shift   (win_shift),
    .push_v  (!hazard),
    .push_rd (cand.rd),
    .rs1     (cand.rs1),
    .rs2     (cand.rs2),
    .hazard  (hazard)
  );

  // Program store writes only while not busy; contents survive reset
  always_ff @(posedge clk1) begin
    if (load_en && ((state == ST_IDLE) || (state == ST_DONE))) begin
      prog[load_idx] <= instr_t'(load_word);
    end
  end

  // Sequencer FSM with registered issue fields and status outputs
  always_ff @(posedge clk1) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= '0;
      last        <= '0;
      dcnt        <= '0;
      outw        <= instr_t'(NOP_WORD);
      issue_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      outw        <= instr_t'(NOP_WORD);
      issue_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            pc        <= '0;
            stall_cnt <= '0;
            last      <= last_n;
            if (count == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (hazard) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
          end else begin
            outw        <= cand;
            issue_valid <= 1'b1;
            pc          <= pc + 1'b1;
            if (pc == last) begin
              state <= ST_DRAIN;
              dcnt  <= DCW'(DRAIN_CYC);
            end
          end
        end
        ST_DRAIN: begin
          // Counter reaches zero DRAIN_CYC edges after the last issue;
          // done is raised on the following edge.
          if (dcnt == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            dcnt <= dcnt - 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_issue.sv
// Directed, table-driven bench for pipe_issue.
module tb_pipe_issue;
  import pipe_pkg::*;

  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [3:0]  load_idx = '0;
  logic [21:0] load_word = '0;
  logic        start = 1'b0;
  logic [4:0]  count = '0;
  logic [3:0]  rs1, rs2, rd;
  logic [1:0]  func;
  logic [7:0]  addr;
  logic        issue_valid, busy, done;
  logic [15:0] stall_cnt;

  int ntests = 0;
  int nfail  = 0;

  logic [21:0] expw [5];
  logic [21:0] indep [5];

  typedef struct {
    logic [4:0][21:0] w;
    int               nw;
    logic [4:0]       cnt;
    logic [19:0]      mask;
    int               done_k;
    int               stall;
  } vec_t;

  vec_t vecs [3];

  pipe_issue #(
    .DEPTH     (16),
    .AW        (4),
    .HAZ_WIN   (2),
    .DRAIN_CYC (4),
    .NOP_WORD  (22'h0)
  ) dut (
    .clk1        (clk1),
    .rst         (rst),
    .load_en     (load_en),
    .load_idx    (load_idx),
    .load_word   (load_word),
    .start       (start),
    .count       (count),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .func        (func),
    .addr        (addr),
    .issue_valid (issue_valid),
    .busy        (busy),
    .done        (done),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk1 = ~clk1;

  function automatic logic [21:0] mk(input logic [1:0] f, input logic [3:0] d,
                                     input logic [3:0] a, input logic [3:0] b,
                                     input logic [7:0] ad);
    return {f, d, a, b, ad};
  endfunction

  function automatic logic [21:0] outword();
    return {func, rd, rs1, rs2, addr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input logic [3:0] idx, input logic [21:0] w);
    load_en   = 1'b1;
    load_idx  = idx;
    load_word = w;
    @(posedge clk1); #1;
    load_en = 1'b0;
  endtask

  // Start a run and check every cycle up to one past the expected done pulse
  task automatic run_expect(input logic [4:0] cnt, input logic [19:0] mask,
                            input int done_k, input int stall_exp,
                            input logic same_load, input logic [21:0] lw);
    int j = 0;
    count = cnt;
    start = 1'b1;
    if (same_load) begin
      load_en   = 1'b1;
      load_idx  = '0;
      load_word = lw;
    end
    for (int k = 0; k <= done_k + 1; k++) begin
      @(posedge clk1); #1;
      if (k == 0) begin
        start   = 1'b0;
        load_en = 1'b0;
      end
      check("issue_valid", 32'(issue_valid), 32'(mask[k]));
      if (mask[k]) begin
        check("issued_word", 32'(outword()), 32'(expw[j]));
        j++;
      end else begin
        check("bubble_word", 32'(outword()), 32'h0);
      end
      check("busy", 32'(busy), 32'(k < done_k));
      check("done", 32'(done), 32'(k == done_k));
      if (k == done_k) check("stall_cnt", 32'(stall_cnt), 32'(stall_exp));
    end
  endtask

  initial begin
    indep[0] = mk(FUNC_ADD, 4'd1, 4'd5, 4'd3, 8'd125);
    indep[1] = mk(FUNC_SUB, 4'd2, 4'd6, 4'd4, 8'd126);
    indep[2] = mk(FUNC_ADD, 4'd3, 4'd7, 4'd5, 8'd127);
    indep[3] = mk(FUNC_SUB, 4'd4, 4'd8, 4'd6, 8'd128);
    indep[4] = mk(FUNC_ADD, 4'd5, 4'd9, 4'd7, 8'd129);

    // independent: issues at edges 1..5, done 5 edges after last issue
    for (int i = 0; i < 5; i++) vecs[0].w[i] = indep[i];
    vecs[0].nw = 5; vecs[0].cnt = 5'd5; vecs[0].mask = 20'h0003E;
    vecs[0].done_k = 10; vecs[0].stall = 0;
    // back-to-back RAW: r1 written then read -> 2 bubbles
    vecs[1].w = '0;
    vecs[1].w[0] = mk(FUNC_ADD, 4'd1, 4'd5, 4'd3, 8'd10);
    vecs[1].w[1] = mk(FUNC_SUB, 4'd2, 4'd1, 4'd4, 8'd11);
    vecs[1].nw = 2; vecs[1].cnt = 5'd2; vecs[1].mask = 20'h00012;
    vecs[1].done_k = 9; vecs[1].stall = 2;
    // RAW at distance 2 -> 1 bubble
    vecs[2].w = '0;
    vecs[2].w[0] = mk(FUNC_ADD, 4'd1, 4'd5, 4'd3, 8'd20);
    vecs[2].w[1] = mk(FUNC_SUB, 4'd2, 4'd6, 4'd4, 8'd21);
    vecs[2].w[2] = mk(FUNC_ADD, 4'd3, 4'd1, 4'd7, 8'd22);
    vecs[2].nw = 3; vecs[2].cnt = 5'd3; vecs[2].mask = 20'h00016;
    vecs[2].done_k = 9; vecs[2].stall = 1;

    repeat (2) @(posedge clk1);
    #1;
    check("rst_valid", 32'(issue_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_word", 32'(outword()), 32'h0);
    check("rst_stall", 32'(stall_cnt), 32'h0);
    rst = 1'b0;

    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < vecs[v].nw; i++) begin
        load(4'(i), vecs[v].w[i]);
        expw[i] = vecs[v].w[i];
      end
      run_expect(vecs[v].cnt, vecs[v].mask, vecs[v].done_k, vecs[v].stall, 1'b0, '0);
    end

    // count == 0: done on the start edge, nothing issued, never busy
    run_expect(5'd0, 20'h0, 0, 0, 1'b0, '0);

    // reset mid-RUN after two issues
    for (int i = 0; i < 5; i++) load(4'(i), indep[i]);
    count = 5'd5;
    start = 1'b1;
    @(posedge clk1); #1;
    start = 1'b0;
    @(posedge clk1); #1;
    @(posedge clk1); #1;
    check("mid_valid", 32'(issue_valid), 32'h1);
    check("mid_word", 32'(outword()), 32'(indep[1]));
    rst = 1'b1;
    @(posedge clk1); #1;
    rst = 1'b0;
    check("abort_valid", 32'(issue_valid), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_word", 32'(outword()), 32'h0);
    check("abort_stall", 32'(stall_cnt), 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk1); #1;
      check("abort_no_done", 32'(done), 32'h0);
      check("abort_idle", 32'(busy), 32'h0);
    end
    for (int i = 0; i < 3; i++) expw[i] = indep[i];
    run_expect(5'd3, 20'h0000E, 8, 0, 1'b0, '0);

    // load_en while busy is dropped
    count = 5'd5;
    start = 1'b1;
    @(posedge clk1); #1;
    start = 1'b0;
    @(posedge clk1); #1;
    load_en   = 1'b1;
    load_idx  = '0;
    load_word = 22'h3ABCDE;
    @(posedge clk1); #1;
    load_en = 1'b0;
    repeat (12) @(posedge clk1);
    #1;
    check("drop_idle", 32'(busy), 32'h0);
    expw[0] = indep[0];
    run_expect(5'd1, 20'h00002, 6, 0, 1'b0, '0);

    // load_en and start at the same edge: new slot 0 is issued
    expw[0] = 22'h3ABCDE;
    run_expect(5'd1, 20'h00002, 6, 0, 1'b1, 22'h3ABCDE);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
